spi_cmd_target: RTL and testbench

- SPI slave command engine: byte-oriented SPI mode 3 target with an echo service, a 256x8 scratch RAM and a 4-bit bidirectional GPIO port.
- Sits at the board top level, driven by an external SPI host (mselect/mclk/mosi/miso).
- All logic runs on the single system clock; SPI pins are oversampled.

---
 rtl/spi_cmd_pkg.sv | 29 ++
 rtl/spi_cmd_target_if.sv | 9 +
 rtl/spi_byte_phy.sv | 69 ++++++
 rtl/spi_cmd_target.sv | 165 ++++++++++++++++
 tb/tb_spi_cmd_target.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the SPI command target.
package spi_cmd_pkg;

    localparam logic [7:0] CMD_ECHO      = 8'h11;
    localparam logic [7:0] CMD_MEM_WRITE = 8'h12;
    localparam logic [7:0] CMD_MEM_READ  = 8'h13;
    localparam logic [7:0] CMD_GPIO_DIR  = 8'h14;
    localparam logic [7:0] CMD_GPIO_DATA = 8'h15;

    localparam logic [7:0] ACK_OFFSET = 8'h11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ECHO,
        S_WRITE_ADDR,
        S_WRITE_DATA,
        S_READ_ADDR,
        S_READ_DATA,
        S_GPIO_DIR,
        S_GPIO_DATA,
        S_SKIP
    } state_t;

    function automatic logic cmd_known(input logic [7:0] c);
        return (c >= CMD_ECHO) && (c <= CMD_GPIO_DATA);
    endfunction

endpackage

// File: rtl/spi_cmd_target_if.sv
// Host-driven SPI pins (select, clock, data in) seen by the command target.
interface spi_cmd_target_if;
    logic mselect;
    logic mclk;
    logic mosi;

    modport master (output mselect, output mclk, output mosi);
    modport slave  (input  mselect, input  mclk, input  mosi);
endinterface

// File: rtl/spi_byte_phy.sv
// Oversampled SPI mode 3 byte layer: pin synchronizers, mclk edge detect,
// rx/tx shift registers, byte_done pulse and reply load strobe.
module spi_byte_phy (
    input  logic                   clk,
    input  logic                   rst,
    spi_cmd_target_if.slave        spi,
    input  logic [7:0]             reply,
    output logic                   selected_c,
    output logic                   load_c,
    output logic                   byte_done,
    output logic [7:0]             rx_byte,
    output logic                   tx_bit
);

    logic [1:0] ms_q;
    logic [1:0] mc_q;
    logic [1:0] mo_q;
    logic       mc_prev_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] rx_sh_q;
    logic [7:0] tx_sh_q;
    logic       rise_c;
    logic       fall_c;

    assign selected_c = ~ms_q[1];
    assign rise_c     = mc_q[1] & ~mc_prev_q;
    assign fall_c     = ~mc_q[1] & mc_prev_q;
    // bit counter sits at zero only before the first falling edge of a byte
    assign load_c     = selected_c & fall_c & (bit_cnt_q == 3'd0);
    assign tx_bit     = tx_sh_q[7];

    always_ff @(posedge clk) begin
        if (rst) begin
            ms_q      <= 2'b11;
            mc_q      <= 2'b11;
            mo_q      <= 2'b00;
            mc_prev_q <= 1'b1;
            bit_cnt_q <= 3'd0;
            rx_sh_q   <= 8'h00;
            tx_sh_q   <= 8'h00;
            rx_byte   <= 8'h00;
            byte_done <= 1'b0;
        end else begin
            ms_q      <= {ms_q[0], spi.mselect};
            mc_q      <= {mc_q[0], spi.mclk};
            mo_q      <= {mo_q[0], spi.mosi};
            mc_prev_q <= mc_q[1];
            byte_done <= 1'b0;

            if (!selected_c) begin
                bit_cnt_q <= 3'd0;
            end else if (rise_c) begin
                rx_sh_q   <= {rx_sh_q[6:0], mo_q[1]};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    byte_done <= 1'b1;
                    rx_byte   <= {rx_sh_q[6:0], mo_q[1]};
                end
            end

            if (load_c) begin
                tx_sh_q <= reply;
            end else if (selected_c && fall_c) begin
                tx_sh_q <= {tx_sh_q[6:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/spi_cmd_target.sv
// SPI command engine: echo, 2**ADDR_W x 8 scratch RAM and a small bidirectional
// GPIO port behind a byte-oriented SPI mode 3 target.
module spi_cmd_target
    import spi_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned GPIO_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    spi_cmd_target_if.slave    spi,
    output wire                miso,
    inout  wire  [GPIO_W-1:0]  gpio
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    state_t              state_q;
    state_t              state_d;
    logic [7:0]          cmd_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   rd_ptr_q;
    logic [ADDR_W-1:0]   rd_ptr_nxt_c;
    logic [7:0]          rd_data_q;
    logic [7:0]          pend_q;
    logic                pend_vld_q;
    logic [GPIO_W-1:0]   dir_q;
    logic [GPIO_W-1:0]   out_q;
    logic [GPIO_W-1:0]   gpio_s0_q;
    logic [GPIO_W-1:0]   gpio_s1_q;
    logic [7:0]          ram [DEPTH];

    logic                selected_c;
    logic                load_c;
    logic                byte_done;
    logic [7:0]          rx_byte;
    logic                tx_bit;
    logic [7:0]          reply_c;
    logic                ram_we_c;
    logic                rd_issue_c;

    spi_byte_phy u_phy (
        .clk        (clk),
        .rst        (rst),
        .spi        (spi),
        .reply      (reply_c),
        .selected_c (selected_c),
        .load_c     (load_c),
        .byte_done  (byte_done),
        .rx_byte    (rx_byte),
        .tx_bit     (tx_bit)
    );

    assign miso = selected_c ? tx_bit : 1'bz;

    for (genvar i = 0; i < GPIO_W; i++) begin : g_gpio
        assign gpio[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state on byte_done, reply byte selection, RAM strobes
    always_comb begin
        state_d      = state_q;
        reply_c      = 8'h00;
        ram_we_c     = 1'b0;
        rd_issue_c   = 1'b0;
        rd_ptr_nxt_c = rd_ptr_q + ADDR_W'(1);

        if (byte_done) begin
            case (state_q)
                S_IDLE:       state_d = cmd_known(rx_byte) ? S_START : S_SKIP;
                S_START: begin
                    case (cmd_q)
                        CMD_ECHO:      state_d = S_ECHO;
                        CMD_MEM_WRITE: state_d = S_WRITE_ADDR;
                        CMD_MEM_READ:  state_d = S_READ_ADDR;
                        CMD_GPIO_DIR:  state_d = S_GPIO_DIR;
                        CMD_GPIO_DATA: state_d = S_GPIO_DATA;
                        default:       state_d = S_SKIP;
                    endcase
                end
                S_WRITE_ADDR: state_d = S_WRITE_DATA;
                S_READ_ADDR:  state_d = S_READ_DATA;
                default:      state_d = state_q;
            endcase
        end
        if (!selected_c) begin
            state_d = S_IDLE;
        end

        if (state_q == S_READ_ADDR) begin
            rd_ptr_nxt_c = addr_q;
        end
        rd_issue_c = byte_done && ((state_q == S_READ_ADDR) || (state_q == S_READ_DATA));
        ram_we_c   = byte_done && selected_c && pend_vld_q && (state_q == S_WRITE_DATA);

        case (state_q)
            S_START:     reply_c = cmd_q + ACK_OFFSET;
            S_ECHO:      reply_c = rx_byte;
            S_READ_DATA: reply_c = rd_data_q;
            S_GPIO_DIR:  reply_c = 8'(dir_q);
            S_GPIO_DATA: reply_c = 8'(gpio_s1_q);
            default:     reply_c = 8'h00;
        endcase
    end

    // Command, address, pending-write and GPIO register updates
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q      <= 8'h00;
            addr_q     <= '0;
            rd_ptr_q   <= '0;
            pend_q     <= 8'h00;
            pend_vld_q <= 1'b0;
            dir_q      <= '0;
            out_q      <= '0;
        end else if (!selected_c) begin
            pend_vld_q <= 1'b0;
        end else if (byte_done) begin
            case (state_q)
                S_IDLE: cmd_q <= rx_byte;
                S_START: begin
                    case (cmd_q)
                        CMD_MEM_WRITE, CMD_MEM_READ: addr_q <= ADDR_W'(rx_byte);
                        CMD_GPIO_DIR:                dir_q  <= rx_byte[GPIO_W-1:0];
                        CMD_GPIO_DATA:               out_q  <= rx_byte[GPIO_W-1:0];
                        default: ;
                    endcase
                end
                S_WRITE_ADDR: begin
                    pend_q     <= rx_byte;
                    pend_vld_q <= 1'b1;
                end
                S_WRITE_DATA: begin
                    pend_q <= rx_byte;
                    addr_q <= addr_q + ADDR_W'(1);
                end
                S_READ_ADDR, S_READ_DATA: rd_ptr_q <= rd_ptr_nxt_c;
                S_GPIO_DIR:  dir_q <= rx_byte[GPIO_W-1:0];
                S_GPIO_DATA: out_q <= rx_byte[GPIO_W-1:0];
                default: ;
            endcase
        end
    end

    // Scratch RAM with registered read and GPIO pin synchronizer (no reset)
    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            ram[addr_q] <= pend_q;
        end
        if (rd_issue_c) begin
            rd_data_q <= ram[rd_ptr_nxt_c];
        end
        gpio_s0_q <= gpio;
        gpio_s1_q <= gpio_s0_q;
    end

endmodule

// File: tb/tb_spi_cmd_target.sv
// Bench for spi_cmd_target: SPI mode 3 host tasks, a transaction-level reference
// model (RAM image, GPIO registers) and directed plus randomized transactions.
module tb_spi_cmd_target;
    import spi_cmd_pkg::*;

    localparam int unsigned HALF = 5;

    logic clk = 1'b0;
    logic rst;
    logic ext_en;
    logic ext_val;
    wire        miso;
    wire  [3:0] gpio;

    int errors = 0;
    int checks = 0;

    logic [7:0] ram_m [256];
    logic [3:0] dir_m;
    logic [3:0] out_m;
    logic [7:0] tx_q  [$];
    logic [7:0] rx_q  [$];
    logic [7:0] exp_q [$];
    logic [7:0] msk_q [$];

    always #5 clk = ~clk;

    spi_cmd_target_if spi ();

    assign gpio[0] = ext_en ? ext_val : 1'bz;

    spi_cmd_target #(.ADDR_W(8), .GPIO_W(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .spi  (spi),
        .miso (miso),
        .gpio (gpio)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int b = 7; b >= 8 - nbits; b--) begin
            spi.mclk = 1'b0;
            spi.mosi = tx[b];
            repeat (HALF) @(negedge clk);
            rx[b] = miso;
            spi.mclk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, rx);
    endtask

    task automatic spi_sel();
        spi.mselect = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic spi_end();
        spi.mselect = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic spi_txn();
        logic [7:0] r;
        rx_q.delete();
        spi_sel();
        foreach (tx_q[i]) begin
            spi_byte(tx_q[i], r);
            rx_q.push_back(r);
        end
    endtask

    // Expected replies for tx_q from the command rules, then apply its side effects
    task automatic model_txn();
        int n;
        logic [7:0] cmd, e, m, a, prev;
        n = tx_q.size();
        exp_q.delete();
        msk_q.delete();
        cmd = tx_q[0];
        for (int i = 0; i < n; i++) begin
            e = 8'h00;
            m = 8'hff;
            if (i >= 1) prev = tx_q[i-1];
            if (i == 1) begin
                e = (cmd >= 8'h11 && cmd <= 8'h15) ? cmd + 8'h11 : 8'h00;
            end else if (i >= 2) begin
                case (cmd)
                    8'h11: e = prev;
                    8'h13: if (i >= 3) begin
                        a = tx_q[1] + 8'(i - 3);
                        e = ram_m[a];
                    end
                    8'h14: e = {4'h0, prev[3:0]};
                    8'h15: begin
                        for (int j = 0; j < 4; j++) e[j] = dir_m[j] ? prev[j] : ext_val;
                        m = {4'hf, dir_m | {3'b000, ext_en}};
                    end
                    default: e = 8'h00;
                endcase
            end
            exp_q.push_back(e);
            msk_q.push_back(m);
        end
        if (n >= 2) begin
            prev = tx_q[n-1];
            case (cmd)
                8'h12: for (int i = 2; i < n - 1; i++) begin
                    a = tx_q[1] + 8'(i - 2);
                    ram_m[a] = tx_q[i];
                end
                8'h14: dir_m = prev[3:0];
                8'h15: out_m = prev[3:0];
                default: ;
            endcase
        end
    endtask

    task automatic run_and_check(input string name);
        model_txn();
        spi_txn();
        spi_end();
        foreach (rx_q[i]) begin
            check($sformatf("%s[%0d]", name, i), 32'(rx_q[i] & msk_q[i]), 32'(exp_q[i] & msk_q[i]));
        end
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] echo_tx [4];
        logic [7:0] echo_rx [4];
        state_t     echo_st [4];
        int         len, sel;

        echo_tx = '{8'h11, 8'h42, 8'h43, 8'h44};
        echo_rx = '{8'h00, 8'h22, 8'h42, 8'h43};
        echo_st = '{S_START, S_ECHO, S_ECHO, S_ECHO};

        rst = 1'b1;
        spi.mselect = 1'b1;
        spi.mclk = 1'b1;
        spi.mosi = 1'b0;
        ext_en = 1'b0;
        ext_val = 1'b0;
        dir_m = 4'h0;
        out_m = 4'h0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_state", 32'(dut.state_q), 32'(S_IDLE));
        check("rst_dir", 32'(dut.dir_q), 32'h0);
        check("rst_out", 32'(dut.out_q), 32'h0);

        // Fill the whole RAM, wrapping from a random start address
        tx_q.delete();
        tx_q.push_back(8'h12);
        tx_q.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < 257; i++) tx_q.push_back(8'($urandom));
        run_and_check("fill");

        // Echo with per-byte state tracking
        spi_sel();
        for (int i = 0; i < 4; i++) begin
            spi_byte(echo_tx[i], r);
            check($sformatf("echo_rx%0d", i), 32'(r), 32'(echo_rx[i]));
            check($sformatf("echo_st%0d", i), 32'(dut.state_q), 32'(echo_st[i]));
        end
        spi_end();
        check("echo_idle", 32'(dut.state_q), 32'(S_IDLE));

        // Write 4..5, last byte dropped; then read back 3..6
        tx_q = '{8'h12, 8'h04, 8'hab, 8'hcd, 8'hef};
        run_and_check("wr");
        tx_q = '{8'h13, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        spi_txn();
        check("rd_state", 32'(dut.state_q), 32'(S_READ_DATA));
        spi_end();
        check("rd_ack", 32'(rx_q[1]), 32'h24);
        check("rd_junk", 32'(rx_q[2]), 32'h00);
        check("rd_ram3", 32'(rx_q[3]), 32'(ram_m[3]));
        check("rd_ram4", 32'(rx_q[4]), 32'hab);
        check("rd_ram5", 32'(rx_q[5]), 32'hcd);
        check("rd_ram6", 32'(rx_q[6]), 32'(ram_m[6]));

        // GPIO pin readback with pin0 driven externally
        ext_en = 1'b1;
        ext_val = 1'b0;
        spi_sel();
        spi_byte(8'h15, r);
        spi_byte(8'h00, r);
        check("gpin_ack", 32'(r), 32'h26);
        spi_byte(8'h00, r);
        check("gpin_lo", 32'(r[0]), 32'h0);
        ext_val = 1'b1;
        spi_byte(8'h00, r);
        check("gpin_hi", 32'({r[7:4], r[0]}), 32'h01);
        spi_end();
        ext_en = 1'b0;
        out_m = 4'h0;

        // Direction then output value
        tx_q = '{8'h14, 8'h01};
        run_and_check("gdir");
        check("gdir_ack", 32'(rx_q[1]), 32'h25);
        check("gdir_reg", 32'(dut.dir_q), 32'h1);
        check("gpio0_lo", 32'(gpio[0]), 32'h0);
        tx_q = '{8'h15, 8'h01};
        run_and_check("gout");
        check("gpio0_hi", 32'(gpio[0]), 32'h1);

        // Abort mid-byte with a pending write outstanding
        spi_sel();
        spi_byte(8'h12, r);
        spi_byte(8'h80, r);
        spi_byte(8'h5a, r);
        spi_bits(8'hc3, 4, r);
        spi.mselect = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_idle", 32'(dut.state_q), 32'(S_IDLE));
        repeat (4) @(negedge clk);
        tx_q = '{8'h11, 8'h77, 8'h78};
        run_and_check("post_abort");
        tx_q = '{8'h13, 8'h7f, 8'h00, 8'h00, 8'h00, 8'h00};
        run_and_check("abort_rd");

        // Randomized transactions against the model
        for (int t = 0; t < 24; t++) begin
            sel = $urandom_range(0, 6);
            len = $urandom_range(1, 10);
            tx_q.delete();
            if (sel <= 4)      tx_q.push_back(8'h11 + 8'(sel));
            else if (sel == 5) tx_q.push_back(8'($urandom_range(8'h16, 8'hff)));
            else               tx_q.push_back(8'h13);
            for (int i = 1; i < len; i++) tx_q.push_back(8'($urandom));
            run_and_check($sformatf("rnd%0d", t));
        end

        // Full RAM readback
        tx_q.delete();
        tx_q.push_back(8'h13);
        tx_q.push_back(8'h00);
        for (int i = 0; i < 257; i++) tx_q.push_back(8'h00);
        run_and_check("final_rd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
